// File: rtl/redirect_arbiter.sv
// redirect_arbiter: prioritises WB/EX/ID/PRIV redirects into a single registered fetch PC-set pulse.
// Ports: clk, rst (sync, active-high); {wb,ex,id,priv}_redir_valid/_pc requests (WB highest);
//        fetch_ready from the fetch PC stage; pc_set_valid/target/src, half_group, flush_if,
//        flush_ex issue pulses; epoch fetch tag; busy while not IDLE.
module redirect_arbiter #(
  parameter int DRAIN_CYCLES = 2,
  parameter int EPOCH_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_redir_valid,
  input  logic [31:0]        wb_redir_pc,
  input  logic               ex_redir_valid,
  input  logic [31:0]        ex_redir_pc,
  input  logic               id_redir_valid,
  input  logic [31:0]        id_redir_pc,
  input  logic               priv_redir_valid,
  input  logic [31:0]        priv_redir_pc,
  input  logic               fetch_ready,
  output logic               pc_set_valid,
  output logic [31:0]        pc_set_target,
  output logic [1:0]         pc_set_src,
  output logic               half_group,
  output logic               flush_if,
  output logic               flush_ex,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy
);
  localparam int CW = $clog2(DRAIN_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, PEND, DRAIN} state_t;
  state_t state, state_nx;
  logic [31:0] pend_pc, win_pc, cand_pc;
  logic [1:0] pend_src, win_src, cand_src;
  logic [CW-1:0] cnt;
  logic [3:0] req, allow, v;
  logic acc, go, issue;
  assign req = {wb_redir_valid, ex_redir_valid, id_redir_valid, priv_redir_valid};
  // PEND admits only requests at or above the pending priority; DRAIN only WB/EX
  assign allow = state == PEND ? 4'b1111 << pend_src : state == DRAIN ? 4'b1100 : 4'b1111;
  assign v = req & allow;
  assign acc = |v;
  assign win_src = v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
  assign win_pc = v[3] ? wb_redir_pc : v[2] ? ex_redir_pc : v[1] ? id_redir_pc : priv_redir_pc;
  // an admitted request always ranks >= the pending one, so it simply replaces it
  assign cand_src = acc ? win_src : pend_src;
  assign cand_pc = acc ? win_pc : pend_pc;
  assign go = acc || state == PEND;
  assign issue = go && fetch_ready;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = IDLE;
    if (issue) state_nx = DRAIN;
    else if (go) state_nx = PEND;
    else if (state == DRAIN && cnt != '0) state_nx = DRAIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend_pc <= '0;
      pend_src <= '0;
      cnt <= '0;
      epoch <= '0;
      pc_set_valid <= 1'b0;
      pc_set_target <= '0;
      pc_set_src <= '0;
      half_group <= 1'b0;
      flush_if <= 1'b0;
      flush_ex <= 1'b0;
    end else begin
      state <= state_nx;
      pend_pc <= go && !issue ? cand_pc : '0;
      pend_src <= go && !issue ? cand_src : '0;
      cnt <= issue ? CW'(DRAIN_CYCLES) : cnt != '0 ? cnt - CW'(1) : '0;
      if (issue) epoch <= epoch + EPOCH_W'(1);
      pc_set_valid <= issue;
      pc_set_target <= issue ? cand_pc : '0;
      pc_set_src <= issue ? cand_src : '0;
      half_group <= issue && cand_pc[2];
      flush_if <= issue;
      flush_ex <= issue && cand_src == 2'd3;
    end
  end
endmodule

// File: tb/tb_redirect_arbiter.sv
// tb_redirect_arbiter: directed self-checking bench for redirect_arbiter.
module tb_redirect_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic wb_v, ex_v, id_v, pr_v, fr;
  logic [31:0] wb_pc, ex_pc, id_pc, pr_pc;
  logic pc_set_valid, half_group, flush_if, flush_ex, busy;
  logic [31:0] pc_set_target;
  logic [1:0] pc_set_src;
  logic [2:0] epoch;
  int errs = 0;
  int checks = 0;
  redirect_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_redir_valid(wb_v), .wb_redir_pc(wb_pc),
    .ex_redir_valid(ex_v), .ex_redir_pc(ex_pc),
    .id_redir_valid(id_v), .id_redir_pc(id_pc),
    .priv_redir_valid(pr_v), .priv_redir_pc(pr_pc),
    .fetch_ready(fr),
    .pc_set_valid(pc_set_valid), .pc_set_target(pc_set_target), .pc_set_src(pc_set_src),
    .half_group(half_group), .flush_if(flush_if), .flush_ex(flush_ex),
    .epoch(epoch), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    wb_v = 0; ex_v = 0; id_v = 0; pr_v = 0;
  endtask
  task automatic chk_issue(input string tag, input logic [31:0] pc, input logic [1:0] src, input logic [2:0] ep);
    chk({tag, ".valid"}, 32'(pc_set_valid), 32'd1);
    chk({tag, ".target"}, pc_set_target, pc);
    chk({tag, ".src"}, 32'(pc_set_src), 32'(src));
    chk({tag, ".half"}, 32'(half_group), 32'(pc[2]));
    chk({tag, ".flush_if"}, 32'(flush_if), 32'd1);
    chk({tag, ".flush_ex"}, 32'(flush_ex), 32'(src == 2'd3));
    chk({tag, ".epoch"}, 32'(epoch), 32'(ep));
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, ".out"}, {pc_set_valid, flush_if, flush_ex, half_group, pc_set_src, pc_set_target[25:0]}, 32'd0);
  endtask
  initial begin
    clr(); fr = 0; rst = 1;
    wb_pc = 0; ex_pc = 0; id_pc = 0; pr_pc = 0;
    tick(); tick();
    chk_quiet("reset");
    chk("reset.target", pc_set_target, 32'd0);
    chk("reset.epoch", 32'(epoch), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    rst = 0;
    // single EX redirect from IDLE
    fr = 1; ex_v = 1; ex_pc = 32'h1c000104;
    tick(); clr();
    chk_issue("ex_idle", 32'h1c000104, 2'd2, 3'd1);
    chk("ex_idle.busy", 32'(busy), 32'd1);
    tick();
    chk("ex_idle.pulse", 32'(pc_set_valid), 32'd0);
    tick();
    chk("ex_idle.drain", 32'(busy), 32'd1);
    tick();
    chk("ex_idle.idle", 32'(busy), 32'd0);
    // WB beats EX and ID in the same cycle
    wb_v = 1; wb_pc = 32'h1c008000; ex_v = 1; ex_pc = 32'h1c000500; id_v = 1; id_pc = 32'h1c000600;
    tick(); clr();
    chk_issue("wb_prio", 32'h1c008000, 2'd3, 3'd2);
    tick();
    chk("wb_prio.single", 32'(pc_set_valid), 32'd0);
    tick(); tick();
    chk("wb_prio.idle", 32'(busy), 32'd0);
    // pending overwrite while fetch stalls
    fr = 0; id_pc = 32'h1c000200; ex_pc = 32'h1c000300;
    for (int c = 0; c <= 9; c++) begin
      if (c >= 1) begin
        chk($sformatf("pend.busy%0d", c), 32'(busy), 32'(c <= 8));
        chk($sformatf("pend.valid%0d", c), 32'(pc_set_valid), 32'(c == 6));
        if (c == 6) chk_issue("pend", 32'h1c000300, 2'd2, 3'd3);
      end
      id_v = c == 0; ex_v = c == 2; fr = c >= 5;
      tick();
    end
    clr();
    // ID dropped in DRAIN, WB preempts
    fr = 1; ex_pc = 32'h1c000400; id_pc = 32'h1c000500; wb_pc = 32'h1c000604;
    for (int c = 0; c <= 7; c++) begin
      chk($sformatf("drain.valid%0d", c), 32'(pc_set_valid), 32'(c == 1 || c == 4));
      if (c == 1) chk_issue("drain1", 32'h1c000400, 2'd2, 3'd4);
      if (c == 4) chk_issue("drain2", 32'h1c000604, 2'd3, 3'd5);
      if (c == 7) chk("drain.idle", 32'(busy), 32'd0);
      ex_v = c == 0; id_v = c == 2; wb_v = c == 3;
      tick();
    end
    clr();
    // epoch wrap over eight back-to-back WB issues
    rst = 1; tick(); rst = 0;
    chk("wrap.epoch0", 32'(epoch), 32'd0);
    wb_v = 1;
    for (int i = 1; i <= 8; i++) begin
      wb_pc = 32'h1c001000 + 32'(i * 4);
      tick();
      chk_issue($sformatf("wrap%0d", i), 32'h1c001000 + 32'(i * 4), 2'd3, 3'(i % 8));
    end
    clr();
    // reset while PEND discards the pending redirect
    fr = 0; ex_v = 1; ex_pc = 32'h1c000700;
    tick(); clr();
    chk("rstpend.busy", 32'(busy), 32'd1);
    chk("rstpend.valid", 32'(pc_set_valid), 32'd0);
    rst = 1; fr = 1;
    tick(); rst = 0;
    for (int c = 0; c < 4; c++) begin
      chk_quiet($sformatf("rstpend%0d", c));
      chk($sformatf("rstpend.epoch%0d", c), 32'(epoch), 32'd0);
      chk($sformatf("rstpend.busy%0d", c), 32'(busy), 32'd0);
      tick();
    end
    // PEND: lower priority dropped, equal priority newest wins, ID not admitted
    fr = 0; ex_v = 1; ex_pc = 32'h1c000800;
    tick(); clr();
    pr_v = 1; pr_pc = 32'h1c000900;
    tick(); clr();
    ex_v = 1; ex_pc = 32'h1c000a04;
    tick(); clr();
    chk("tie.valid", 32'(pc_set_valid), 32'd0);
    fr = 1; id_v = 1; id_pc = 32'h1c000b00;
    tick(); clr();
    chk_issue("tie", 32'h1c000a04, 2'd2, 3'd1);
    tick();
    chk("tie.single", 32'(pc_set_valid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
